// File: rtl/assoc_mem_pkg.sv
// +--------------------------------------------------------------------------+
// | Module : assoc_mem_pkg                                                    |
// | Desc   : Shared op/state encodings and index-width helper for assoc_mem. |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package assoc_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INVAL = 2'b10,
        OP_FLUSH = 2'b11
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic int idx_w(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/assoc_mem_match.sv
// +--------------------------------------------------------------------------+
// | Module : assoc_mem_match                                                  |
// | Desc   : Parallel key compare with one-hot encode and lowest-free search.|
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module assoc_mem_match
    import assoc_mem_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 4,
    parameter int IDX_W   = idx_w(ENTRIES)
) (
    input  logic [ADDR_W-1:0]  keys [ENTRIES],
    input  logic [ENTRIES-1:0] valid,
    input  logic [ADDR_W-1:0]  addr,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               free_found,
    output logic [IDX_W-1:0]   free_idx
);

    logic [ENTRIES-1:0] w_onehot;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
        assign w_onehot[gi] = valid[gi] && (keys[gi] == addr);
    end

    assign hit = |w_onehot;

    // Keys are unique among valid entries, so OR-ing indices yields the match.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_onehot[i]) begin
                hit_idx = hit_idx | IDX_W'(i);
            end
        end
    end

    // Scan high to low so the lowest free index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/assoc_mem_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module : assoc_mem_ctrl                                                   |
// | Desc   : Fully-associative key/data store with update-in-place,          |
// |          round-robin replacement, invalidate and sequenced flush.        |
// |          Define ASSOC_MEM_STATS_EN to enable READ hit/miss counters.     |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module assoc_mem_ctrl
    import assoc_mem_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_evict,
    output logic [DATA_W-1:0] rsp_data,
    output logic              full,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int IDX_W = idx_w(ENTRIES);

    logic [ADDR_W-1:0]  r_key  [ENTRIES];
    logic [DATA_W-1:0]  r_data [ENTRIES];
    logic [ENTRIES-1:0] r_valid;
    logic [IDX_W-1:0]   r_victim;
    logic [IDX_W-1:0]   r_flush_idx;
    state_e             r_state;

    op_e                w_op;
    logic               w_accept;
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_wr_en;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_evict;

    assign w_op      = op_e'(req_op);
    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign full      = &r_valid;

    assoc_mem_match #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .IDX_W   (IDX_W)
    ) u_match (
        .keys       (r_key),
        .valid      (r_valid),
        .addr       (req_addr),
        .hit        (w_hit),
        .hit_idx    (w_hit_idx),
        .free_found (w_free_found),
        .free_idx   (w_free_idx)
    );

    // WRITE target: matching entry, else lowest free, else round-robin victim.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = w_hit_idx;
        w_evict  = 1'b0;
        if (w_accept && (w_op == OP_WRITE)) begin
            w_wr_en = 1'b1;
            if (w_hit) begin
                w_wr_idx = w_hit_idx;
            end else if (w_free_found) begin
                w_wr_idx = w_free_idx;
            end else begin
                w_wr_idx = r_victim;
                w_evict  = 1'b1;
            end
        end
    end

    // Key/data payload is deliberately left out of reset; only valid bits matter.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_key[w_wr_idx]  <= req_addr;
            r_data[w_wr_idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_valid     <= '0;
            r_victim    <= '0;
            r_flush_idx <= '0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_evict   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_evict <= 1'b0;
            rsp_data  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_READ: begin
                                rsp_valid <= 1'b1;
                                rsp_hit   <= w_hit;
                                rsp_data  <= w_hit ? r_data[w_hit_idx] : '0;
                            end
                            OP_WRITE: begin
                                rsp_valid         <= 1'b1;
                                rsp_hit           <= w_hit;
                                rsp_evict         <= w_evict;
                                r_valid[w_wr_idx] <= 1'b1;
                                if (w_evict) begin
                                    r_victim <= r_victim + 1'b1;
                                end
                            end
                            OP_INVAL: begin
                                rsp_valid <= 1'b1;
                                rsp_hit   <= w_hit;
                                if (w_hit) begin
                                    r_valid[w_hit_idx] <= 1'b0;
                                end
                            end
                            OP_FLUSH: begin
                                r_state     <= ST_FLUSH;
                                r_flush_idx <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_FLUSH: begin
                    r_valid[r_flush_idx] <= 1'b0;
                    if (r_flush_idx == IDX_W'(ENTRIES - 1)) begin
                        r_state     <= ST_IDLE;
                        r_flush_idx <= '0;
                        r_victim    <= '0;
                        rsp_valid   <= 1'b1;
                    end else begin
                        r_flush_idx <= r_flush_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ASSOC_MEM_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Saturating counters; FLUSH leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept && (w_op == OP_READ)) begin
            if (w_hit) begin
                if (!(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
                if (!(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_assoc_mem_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module : tb_assoc_mem_ctrl                                                |
// | Desc   : Directed + random checks of assoc_mem_ctrl vs. a slot model.    |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_assoc_mem_ctrl;

    localparam int ENTRIES = 4;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int CNT_W   = 16;

    localparam logic [1:0] C_RD = 2'b00;
    localparam logic [1:0] C_WR = 2'b01;
    localparam logic [1:0] C_IV = 2'b10;
    localparam logic [1:0] C_FL = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_hit;
    logic              rsp_evict;
    logic [DATA_W-1:0] rsp_data;
    logic              full;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    assoc_mem_ctrl #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .rsp_evict (rsp_evict),
        .rsp_data  (rsp_data),
        .full      (full),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: slot table plus replacement pointer, as the behaviour is described.
    bit          m_valid [ENTRIES];
    logic [3:0]  m_key   [ENTRIES];
    logic [3:0]  m_data  [ENTRIES];
    int          m_victim;
    int          m_hits;
    int          m_misses;

    logic        last_hit;
    logic        last_evict;
    logic [3:0]  last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_find(input logic [3:0] a);
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_key[i] == a) return i;
        return -1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < ENTRIES; i++)
            if (!m_valid[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_victim = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    task automatic chk_cnt(input string tag);
`ifdef ASSOC_MEM_STATS_EN
        chk({tag, "_hit_cnt"}, 32'(hit_cnt), m_hits);
        chk({tag, "_miss_cnt"}, 32'(miss_cnt), m_misses);
`else
        chk({tag, "_hit_cnt"}, 32'(hit_cnt), 0);
        chk({tag, "_miss_cnt"}, 32'(miss_cnt), 0);
`endif
    endtask

    // One READ/WRITE/INVAL transaction: accept on the next edge, response right after.
    task automatic do_req(input logic [1:0] op, input logic [3:0] a, input logic [3:0] wd);
        bit         e_hit;
        bit         e_evict;
        logic [3:0] e_data;
        int         i;
        int         f;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        chk("req_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e_hit = 0; e_evict = 0; e_data = 4'h0;
        i = m_find(a);
        case (op)
            C_RD: begin
                e_hit = (i >= 0);
                if (e_hit) begin
                    e_data = m_data[i];
                    m_hits++;
                end else begin
                    m_misses++;
                end
            end
            C_WR: begin
                if (i >= 0) begin
                    e_hit = 1;
                    m_data[i] = wd;
                end else begin
                    f = -1;
                    for (int k = ENTRIES - 1; k >= 0; k--)
                        if (!m_valid[k]) f = k;
                    if (f < 0) begin
                        f = m_victim;
                        e_evict = 1;
                        m_victim = (m_victim + 1) % ENTRIES;
                    end
                    m_valid[f] = 1'b1;
                    m_key[f]   = a;
                    m_data[f]  = wd;
                end
            end
            default: begin
                if (i >= 0) begin
                    e_hit = 1;
                    m_valid[i] = 1'b0;
                end
            end
        endcase
        last_hit   = rsp_hit;
        last_evict = rsp_evict;
        last_data  = rsp_data;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
        chk("rsp_evict", 32'(rsp_evict), 32'(e_evict));
        chk("rsp_data", 32'(rsp_data), 32'(e_data));
        chk("full", 32'(full), 32'(m_full()));
        chk_cnt("req");
    endtask

    // FLUSH with req_valid held for the whole busy window.
    task automatic do_flush();
        int k;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = C_FL;
        req_addr  = 4'h0;
        chk("flush_ready_in", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        k = 0;
        while (!rsp_valid && k < 20) begin
            chk("flush_busy_ready", 32'(req_ready), 0);
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_victim = 0;
        chk("flush_latency", k, ENTRIES);
        chk("flush_rsp_hit", 32'(rsp_hit), 0);
        chk("flush_rsp_evict", 32'(rsp_evict), 0);
        chk("flush_rsp_data", 32'(rsp_data), 0);
        chk("flush_ready_out", 32'(req_ready), 1);
        chk("flush_full", 32'(full), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = C_RD;
        req_addr  = '0;
        req_wdata = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_full", 32'(full), 0);
        chk_cnt("rst");

        // Directed scenario from the block description.
        do_req(C_RD, 4'h3, 4'h0);
        chk("rd3_empty_hit", 32'(last_hit), 0);
        do_req(C_WR, 4'h1, 4'hA);
        do_req(C_WR, 4'h2, 4'hB);
        do_req(C_WR, 4'h3, 4'hC);
        do_req(C_WR, 4'h4, 4'hD);
        chk("full_after_4", 32'(full), 1);
        do_req(C_RD, 4'h3, 4'h0);
        chk("rd3_data_C", 32'(last_data), 32'hC);
        do_req(C_WR, 4'h3, 4'hE);
        chk("wr3_upd_evict", 32'(last_evict), 0);
        do_req(C_RD, 4'h3, 4'h0);
        chk("rd3_data_E", 32'(last_data), 32'hE);
        do_req(C_WR, 4'h5, 4'h5);
        chk("wr5_evict", 32'(last_evict), 1);
        do_req(C_RD, 4'h1, 4'h0);
        chk("rd1_gone", 32'(last_hit), 0);
        do_req(C_WR, 4'h6, 4'h6);
        chk("wr6_evict", 32'(last_evict), 1);
        do_req(C_RD, 4'h2, 4'h0);
        chk("rd2_gone", 32'(last_hit), 0);
        do_req(C_IV, 4'h3, 4'h0);
        chk("inv3_hit", 32'(last_hit), 1);
        chk("inv3_full", 32'(full), 0);
        do_req(C_WR, 4'h7, 4'h7);
        chk("wr7_evict", 32'(last_evict), 0);
        do_req(C_IV, 4'h9, 4'h0);
        chk("inv9_hit", 32'(last_hit), 0);
        do_flush();
        do_req(C_RD, 4'h5, 4'h0);
        chk("rd5_after_flush", 32'(last_hit), 0);

        // Randomized mix over a small key space to keep hits and evictions frequent.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 35)
                do_req(C_RD, 4'($urandom_range(0, 7)), 4'h0);
            else if (r < 75)
                do_req(C_WR, 4'($urandom_range(0, 7)), 4'($urandom));
            else if (r < 96)
                do_req(C_IV, 4'($urandom_range(0, 7)), 4'h0);
            else
                do_flush();
        end

        // Reset in the middle of a flush sweep, with the table full beforehand.
        for (int a = 8; a < 12; a++) do_req(C_WR, 4'(a), 4'(a));
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = C_FL;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        m_reset();
        chk("midrst_ready", 32'(req_ready), 1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_full", 32'(full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt("midrst");
        for (int a = 0; a < 16; a++) do_req(C_RD, 4'(a), 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
